controlador_minado: RTL and testbench

CONTROLADOR_MINADO -- requirements
Module: controlador_minado

---
 rtl/controlador_minado.sv | 116 +++++++++++
 tb/tb_controlador_minado.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/controlador_minado.sv
// Nonce-dispatch controller for a bank of parallel hash cores: hands out nonce
// ranges round by round and latches the first winning core or the round-limit stop.
module controlador_minado #(
    parameter  int NUM_BLOQUES = 4,
    parameter  int ANCHO_NONCE = 32,
    localparam int IW          = (NUM_BLOQUES > 1) ? $clog2(NUM_BLOQUES) : 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               inicio,
    input  logic [ANCHO_NONCE-1:0]             nonce_base,
    input  logic [31:0]                        limite_rondas,
    input  logic [NUM_BLOQUES-1:0]             terminado_in,
    input  logic [NUM_BLOQUES-1:0]             exito_in,
    output logic [NUM_BLOQUES*ANCHO_NONCE-1:0] nonce_out,
    output logic [NUM_BLOQUES-1:0]             arranque_out,
    output logic [ANCHO_NONCE-1:0]             nonce_ganador,
    output logic [IW-1:0]                      indice_ganador,
    output logic                               encontrado,
    output logic                               agotado,
    output logic                               ocupado,
    output logic [31:0]                        rondas
);

    typedef enum logic [1:0] {REPOSO, LANZA, ESPERA, FIN} estado_t;

    estado_t                                   estado;
    logic [NUM_BLOQUES-1:0][ANCHO_NONCE-1:0]   nonces;
    logic [NUM_BLOQUES-1:0]                    pendiente;
    logic [NUM_BLOQUES-1:0]                    mask_nuevo;
    logic [31:0]                               limite;
    logic [31:0]                               rondas_inc;
    logic [IW-1:0]                             hit_idx;
    logic                                      hay_hit;
    logic                                      ronda_fin;

    assign nonce_out    = nonces;
    assign arranque_out = {NUM_BLOQUES{estado == LANZA}};
    assign ocupado      = (estado == LANZA) || (estado == ESPERA);
    assign mask_nuevo   = pendiente | terminado_in;
    assign ronda_fin    = &mask_nuevo;
    assign rondas_inc   = (rondas == 32'hFFFF_FFFF) ? rondas : rondas + 32'd1;

    // Scan downwards so the lowest reporting core is the one left standing.
    always_comb begin
        hay_hit = 1'b0;
        hit_idx = '0;
        for (int i = NUM_BLOQUES - 1; i >= 0; i--) begin
            if (terminado_in[i] && exito_in[i]) begin
                hay_hit = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado         <= REPOSO;
            nonces         <= '0;
            pendiente      <= '0;
            limite         <= '0;
            rondas         <= '0;
            nonce_ganador  <= '0;
            indice_ganador <= '0;
            encontrado     <= 1'b0;
            agotado        <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        estado <= LANZA;
                        for (int i = 0; i < NUM_BLOQUES; i++)
                            nonces[i] <= nonce_base + ANCHO_NONCE'(i);
                        limite         <= limite_rondas;
                        rondas         <= '0;
                        pendiente      <= '0;
                        nonce_ganador  <= '0;
                        indice_ganador <= '0;
                        encontrado     <= 1'b0;
                        agotado        <= 1'b0;
                    end
                end
                LANZA: estado <= inicio ? ESPERA : REPOSO;
                ESPERA: begin
                    if (!inicio) begin
                        estado <= REPOSO;
                    end else begin
                        pendiente <= mask_nuevo;
                        if (ronda_fin)
                            rondas <= rondas_inc;
                        // A hit wins over a simultaneous round completion.
                        if (hay_hit) begin
                            estado         <= FIN;
                            nonce_ganador  <= nonces[hit_idx];
                            indice_ganador <= hit_idx;
                            encontrado     <= 1'b1;
                        end else if (ronda_fin) begin
                            if (limite != 32'd0 && rondas_inc == limite) begin
                                estado  <= FIN;
                                agotado <= 1'b1;
                            end else begin
                                estado    <= LANZA;
                                pendiente <= '0;
                                for (int i = 0; i < NUM_BLOQUES; i++)
                                    nonces[i] <= nonces[i] + ANCHO_NONCE'(NUM_BLOQUES);
                            end
                        end
                    end
                end
                FIN: if (!inicio) estado <= REPOSO;
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_minado.sv
// Scoreboard bench for controlador_minado: stimulus queues expected launches and
// results, a negedge monitor pops and compares whenever the DUT presents one.
module tb_controlador_minado;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         inicio;
    logic [31:0]  nonce_base;
    logic [31:0]  limite_rondas;
    logic [3:0]   terminado_in;
    logic [3:0]   exito_in;
    logic [127:0] nonce_out;
    logic [3:0]   arranque_out;
    logic [31:0]  nonce_ganador;
    logic [1:0]   indice_ganador;
    logic         encontrado;
    logic         agotado;
    logic         ocupado;
    logic [31:0]  rondas;

    controlador_minado dut (
        .clk(clk), .reset_n(reset_n), .inicio(inicio), .nonce_base(nonce_base),
        .limite_rondas(limite_rondas), .terminado_in(terminado_in), .exito_in(exito_in),
        .nonce_out(nonce_out), .arranque_out(arranque_out), .nonce_ganador(nonce_ganador),
        .indice_ganador(indice_ganador), .encontrado(encontrado), .agotado(agotado),
        .ocupado(ocupado), .rondas(rondas)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           kind;   // 0 = launch, 1 = result
        logic [127:0] nonces;
        logic [31:0]  ganador;
        logic [1:0]   idx;
        logic         enc;
        logic         ag;
        logic [31:0]  rnd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic fin_prev = 1'b0;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [31:0] base);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic push_launch(input logic [31:0] base);
        exp_t e;
        e.kind = 1'b0; e.nonces = mk(base); e.ganador = '0; e.idx = '0;
        e.enc = 1'b0; e.ag = 1'b0; e.rnd = '0;
        sb.push_back(e);
    endtask

    task automatic push_result(input logic [31:0] base, input logic [31:0] gan,
                               input logic [1:0] idx, input logic enc, input logic ag,
                               input logic [31:0] rnd);
        exp_t e;
        e.kind = 1'b1; e.nonces = mk(base); e.ganador = gan; e.idx = idx;
        e.enc = enc; e.ag = ag; e.rnd = rnd;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        logic fin;
        if (reset_n) begin
            if (arranque_out != 4'h0) begin
                if (sb.size() == 0) chk("launch_unexpected", 200'(arranque_out), 200'h0);
                else begin
                    e = sb.pop_front();
                    chk("launch_kind", 200'(e.kind), 200'(1'b0));
                    chk("arranque", 200'(arranque_out), 200'(4'hF));
                    chk("launch_nonces", 200'(nonce_out), 200'(e.nonces));
                end
            end
            fin = encontrado | agotado;
            if (fin && !fin_prev) begin
                if (sb.size() == 0) chk("result_unexpected", 200'(fin), 200'h0);
                else begin
                    e = sb.pop_front();
                    chk("result_kind", 200'(e.kind), 200'(1'b1));
                    chk("result", {encontrado, agotado, indice_ganador, nonce_ganador, rondas, nonce_out},
                        {e.enc, e.ag, e.idx, e.ganador, e.rnd, e.nonces});
                    chk("result_ocupado", 200'(ocupado), 200'h0);
                end
            end
            fin_prev = fin;
        end else begin
            fin_prev = 1'b0;
        end
    end

    task automatic start(input logic [31:0] base, input logic [31:0] lim);
        @(posedge clk); #1;
        nonce_base = base; limite_rondas = lim; inicio = 1'b1;
    endtask

    task automatic ronda(input logic [3:0] t, input logic [3:0] e);
        repeat (2) @(posedge clk);
        #1 terminado_in = t; exito_in = e;
        @(posedge clk);
        #1 terminado_in = '0; exito_in = '0;
    endtask

    task automatic stop();
        @(posedge clk); #1 inicio = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; inicio = 1'b0; nonce_base = '0; limite_rondas = '0;
        terminado_in = '0; exito_in = '0;
        #12;
        chk("reset_outputs", {nonce_out, arranque_out, nonce_ganador, indice_ganador, encontrado, agotado, ocupado, rondas}, '0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("idle_after_reset", 200'({ocupado, arranque_out}), 200'h0);

        // Two empty rounds, then cores 1 and 3 hit together: core 1 wins.
        push_launch(32'd0); push_launch(32'd4); push_launch(32'd8);
        push_result(32'd8, 32'd9, 2'd1, 1'b1, 1'b0, 32'd2);
        start(32'd0, 32'd0);
        ronda(4'hF, 4'h0);
        ronda(4'hF, 4'h0);
        ronda(4'b1010, 4'b1010);
        repeat (3) @(posedge clk); #1;
        chk("fin_hold", {encontrado, ocupado, indice_ganador, nonce_ganador}, {1'b1, 1'b0, 2'd1, 32'd9});
        stop();
        chk("rearm_idle", 200'(ocupado), 200'h0);

        // Round limit of 3 with no hits.
        push_launch(32'd0); push_launch(32'd4); push_launch(32'd8);
        push_result(32'd8, 32'd0, 2'd0, 1'b0, 1'b1, 32'd3);
        start(32'd0, 32'd3);
        ronda(4'hF, 4'h0);
        ronda(4'hF, 4'h0);
        ronda(4'hF, 4'h0);
        repeat (3) @(posedge clk); #1;
        chk("agotado_hold", {agotado, ocupado, rondas}, {1'b1, 1'b0, 32'd3});
        stop();
        chk("agotado_rearm", 200'(ocupado), 200'h0);

        // Nonce wrap-around.
        push_launch(32'hFFFF_FFFE); push_launch(32'd2);
        push_result(32'd2, 32'd0, 2'd0, 1'b0, 1'b1, 32'd2);
        start(32'hFFFF_FFFE, 32'd2);
        ronda(4'hF, 4'h0);
        ronda(4'hF, 4'h0);
        repeat (2) @(posedge clk);
        stop();

        // Pulses during LANZA are ignored; a repeat pulse from core 2 does not end the round.
        push_launch(32'd100);
        push_result(32'd100, 32'd0, 2'd0, 1'b0, 1'b1, 32'd1);
        start(32'd100, 32'd1);
        @(posedge clk); #1 terminado_in = 4'hF; exito_in = 4'hF;
        @(posedge clk); #1 terminado_in = 4'b0100; exito_in = 4'h0;
        @(posedge clk); #1 terminado_in = 4'b0100;
        @(posedge clk); #1 terminado_in = 4'h0;
        @(posedge clk); #1;
        chk("repeat_pulse_busy", {ocupado, encontrado, agotado, rondas}, {1'b1, 1'b0, 1'b0, 32'd0});
        terminado_in = 4'b1011;
        @(posedge clk); #1 terminado_in = 4'h0;
        repeat (2) @(posedge clk);
        stop();

        // Asynchronous reset mid-search.
        push_launch(32'd0);
        start(32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset", {nonce_out, arranque_out, nonce_ganador, indice_ganador, encontrado, agotado, ocupado, rondas}, '0);
        inicio = 1'b0;
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("no_start_after_reset", 200'({ocupado, arranque_out}), 200'h0);

        // Abort with inicio low during ESPERA; rondas holds.
        push_launch(32'd0); push_launch(32'd4);
        start(32'd0, 32'd0);
        ronda(4'hF, 4'h0);
        repeat (2) @(posedge clk);
        #1 inicio = 1'b0;
        @(posedge clk); #1;
        chk("abort", {ocupado, encontrado, agotado, rondas}, {1'b0, 1'b0, 1'b0, 32'd1});
        repeat (3) @(posedge clk); #1;

        chk("scoreboard_drained", 200'(sb.size()), 200'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
